// File: rtl/ttt_turn_scheduler.sv
// Turn scheduler in front of the tic-tac-toe core: alternates players, rejects bad moves,
// forwards legal moves over valid/ready and tracks occupancy and move count.
// Ports: clk, rst (async, active-high), start, p1_req/p1_pos, p2_req/p2_pos, game_over,
//   mv_valid/mv_ready/mv_player/mv_pos (core handshake), turn, occ, move_cnt,
//   illegal, timeout, busy. All outputs registered.
// Optional turn timer enabled by defining TTT_TIMEOUT_EN.
module ttt_turn_scheduler #(
  parameter int FIRST_PLAYER = 1,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int TIMER_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p1_req,
  input  logic [3:0] p1_pos,
  input  logic       p2_req,
  input  logic [3:0] p2_pos,
  input  logic       game_over,
  output logic       mv_valid,
  input  logic       mv_ready,
  output logic [1:0] mv_player,
  output logic [3:0] mv_pos,
  output logic [1:0] turn,
  output logic [8:0] occ,
  output logic [3:0] move_cnt,
  output logic       illegal,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_P1, S_WAIT_P2, S_ISSUE, S_DONE
  } state_t;

  localparam state_t FIRST_ST =
    (FIRST_PLAYER == 2) ? S_WAIT_P2 : S_WAIT_P1;
  localparam logic [1:0] FIRST_ID =
    (FIRST_PLAYER == 2) ? 2'd2 : 2'd1;

  if (FIRST_PLAYER != 1 && FIRST_PLAYER != 2) begin : g_bad_first
    $error("FIRST_PLAYER must be 1 or 2");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 2**TIMER_W) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be in 1..2**TIMER_W");
  end

  state_t     state_q;
  logic       mv_valid_q;
  logic [1:0] mv_player_q;
  logic [3:0] mv_pos_q;
  logic [1:0] turn_q;
  logic [8:0] occ_q;
  logic [3:0] cnt_q;
  logic       illegal_q;
  logic       busy_q;

  logic       in_p2;
  logic       cur_req;
  logic       oth_req;
  logic [3:0] cur_pos;
  logic [1:0] cur_id;
  logic [1:0] oth_id;
  state_t     oth_st;
  logic [8:0] pos_oh;
  logic [8:0] mv_oh;
  logic       legal;
  logic [8:0] occ_d;
  logic [3:0] cnt_d;

  // The player whose turn it is selects which request port is "own".
  always_comb begin
    in_p2   = (state_q == S_WAIT_P2);
    cur_req = in_p2 ? p2_req : p1_req;
    oth_req = in_p2 ? p1_req : p2_req;
    cur_pos = in_p2 ? p2_pos : p1_pos;
    cur_id  = in_p2 ? 2'd2 : 2'd1;
    oth_id  = in_p2 ? 2'd1 : 2'd2;
    oth_st  = in_p2 ? S_WAIT_P1 : S_WAIT_P2;
    for (int k = 0; k < 9; k++) begin
      pos_oh[k] = (cur_pos == 4'(k + 1));
      mv_oh[k]  = (mv_pos_q == 4'(k + 1));
    end
    // An all-zero one-hot means pos 0 or 10..15.
    legal = cur_req && (|pos_oh) && !(|(occ_q & pos_oh));
    occ_d = occ_q | mv_oh;
    cnt_d = cnt_q + 4'd1;
  end

`ifdef TTT_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TMO_LAST =
    TIMER_W'(TIMEOUT_CYC - 1);
  logic [TIMER_W-1:0] tmr_q;
  logic               timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mv_valid_q  <= 1'b0;
      mv_player_q <= 2'd0;
      mv_pos_q    <= 4'd0;
      turn_q      <= 2'd0;
      occ_q       <= 9'd0;
      cnt_q       <= 4'd0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef TTT_TIMEOUT_EN
      tmr_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      illegal_q <= 1'b0;
`ifdef TTT_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= FIRST_ST;
            turn_q  <= FIRST_ID;
            busy_q  <= 1'b1;
            occ_q   <= 9'd0;
            cnt_q   <= 4'd0;
`ifdef TTT_TIMEOUT_EN
            tmr_q   <= '0;
`endif
          end
        end
        S_WAIT_P1, S_WAIT_P2: begin
`ifdef TTT_TIMEOUT_EN
          tmr_q <= tmr_q + 1'b1;
`endif
          if (!start) begin
            state_q <= S_IDLE;
            turn_q  <= 2'd0;
            busy_q  <= 1'b0;
          end else if (game_over) begin
            state_q <= S_DONE;
            turn_q  <= 2'd0;
          end else begin
            if (oth_req || (cur_req && !legal)) begin
              illegal_q <= 1'b1;
            end
            if (legal) begin
              state_q     <= S_ISSUE;
              mv_valid_q  <= 1'b1;
              mv_player_q <= cur_id;
              mv_pos_q    <= cur_pos;
            end
`ifdef TTT_TIMEOUT_EN
            // A legal move in the expiry cycle wins over the timeout.
            else if (tmr_q == TMO_LAST) begin
              timeout_q <= 1'b1;
              state_q   <= oth_st;
              turn_q    <= oth_id;
              tmr_q     <= '0;
            end
`endif
          end
        end
        S_ISSUE: begin
          if (p1_req || p2_req) begin
            illegal_q <= 1'b1;
          end
          // start is not looked at here; an abort lands in the next WAIT.
          if (mv_ready) begin
            mv_valid_q <= 1'b0;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            if (cnt_d == 4'd9 || game_over) begin
              state_q <= S_DONE;
              turn_q  <= 2'd0;
            end else if (mv_player_q == 2'd1) begin
              state_q <= S_WAIT_P2;
              turn_q  <= 2'd2;
            end else begin
              state_q <= S_WAIT_P1;
              turn_q  <= 2'd1;
            end
`ifdef TTT_TIMEOUT_EN
            tmr_q <= '0;
`endif
          end
        end
        S_DONE: begin
          if (!start) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (p1_req || p2_req) begin
            illegal_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          turn_q  <= 2'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mv_valid  = mv_valid_q;
  assign mv_player = mv_player_q;
  assign mv_pos    = mv_pos_q;
  assign turn      = turn_q;
  assign occ       = occ_q;
  assign move_cnt  = cnt_q;
  assign illegal   = illegal_q;
  assign busy      = busy_q;

endmodule
